// File: rtl/alien_pkg.sv
// Shared definitions for the alien scheduling and movement blocks.
// Holds the scheduler state encoding, direction codes and default slot count.
package alien_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FREEZE,
        CLEARED
    } sched_state_t;

    localparam logic [1:0] ALIEN_DIR_UP    = 2'd0;
    localparam logic [1:0] ALIEN_DIR_DOWN  = 2'd1;
    localparam logic [1:0] ALIEN_DIR_LEFT  = 2'd2;
    localparam logic [1:0] ALIEN_DIR_RIGHT = 2'd3;

    localparam int NUM_ALIENS_DEFAULT = 4;

endpackage

// File: rtl/alien_spawn_scheduler_if.sv
// Game-controller <-> spawn-scheduler signal bundle.
// The master side is the game-state controller; the slave side is the scheduler.
interface alien_spawn_scheduler_if #(
    parameter int NUM_ALIENS = alien_pkg::NUM_ALIENS_DEFAULT
);

    logic                  startOfFrame;
    logic                  level_start;
    logic [NUM_ALIENS-1:0] alien_died;
    logic                  player_died;
    logic [NUM_ALIENS-1:0] spawn_req;
    logic [NUM_ALIENS-1:0] slot_active;
    logic                  freeze;
    logic [7:0]            aliens_remaining;
    logic                  level_cleared;

    modport master (
        output startOfFrame, level_start, alien_died, player_died,
        input  spawn_req, slot_active, freeze, aliens_remaining, level_cleared
    );

    modport slave (
        input  startOfFrame, level_start, alien_died, player_died,
        output spawn_req, slot_active, freeze, aliens_remaining, level_cleared
    );

endinterface

// File: rtl/frame_timer.sv
// 8-bit loadable down-counter advanced by frame ticks; saturates at zero.
// Load takes precedence over tick so a reload on a tick frame is exact.
module frame_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       tick,
    output logic       zero,
    output logic       one
);

    logic [7:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && (cnt != 8'd0)) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign zero = (cnt == 8'd0);
    assign one  = (cnt == 8'd1);

endmodule

// File: rtl/alien_spawn_scheduler.sv
// Shares a pool of alien slots across a level quota: paces spawns per frame,
// caps live aliens, counts kills to level clear and freezes after player death.
module alien_spawn_scheduler
    import alien_pkg::*;
#(
    parameter int NUM_ALIENS     = NUM_ALIENS_DEFAULT,
    parameter int MAX_ALIVE      = 3,
    parameter int TOTAL_ALIENS   = 10,
    parameter int SPAWN_INTERVAL = 64,
    parameter int FREEZE_FRAMES  = 90
) (
    input logic                    clk,
    input logic                    reset,
    alien_spawn_scheduler_if.slave bus
);

    sched_state_t          state, state_nx;
    logic [NUM_ALIENS-1:0] slot_active, slot_active_nx;
    logic [NUM_ALIENS-1:0] spawn_req, spawn_req_nx;
    logic [7:0]            remaining, remaining_nx;
    logic [7:0]            spawned, spawned_nx;
    logic                  freeze, freeze_nx;
    logic                  cleared, cleared_nx;

    logic                  tmr_load;
    logic [7:0]            tmr_load_val;
    logic                  tmr_tick;
    logic                  tmr_zero;
    logic                  tmr_one;

    logic [NUM_ALIENS-1:0] kills;
    logic [NUM_ALIENS-1:0] free_slots;
    logic [NUM_ALIENS-1:0] pick;
    logic [7:0]            kill_cnt;

    frame_timer u_frame_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .tick     (tmr_tick),
        .zero     (tmr_zero),
        .one      (tmr_one)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx       = state;
        slot_active_nx = slot_active;
        spawn_req_nx   = '0;
        remaining_nx   = remaining;
        spawned_nx     = spawned;
        freeze_nx      = freeze;
        cleared_nx     = cleared;
        tmr_load       = 1'b0;
        tmr_load_val   = 8'd0;
        tmr_tick       = 1'b0;
        kills          = '0;
        free_slots     = '0;
        pick           = '0;
        kill_cnt       = 8'd0;

        if (bus.level_start) begin
            state_nx       = RUN;
            slot_active_nx = '0;
            remaining_nx   = 8'(TOTAL_ALIENS);
            spawned_nx     = 8'd0;
            freeze_nx      = 1'b0;
            cleared_nx     = 1'b0;
            tmr_load       = 1'b1;
        end else if ((state == RUN) || (state == FREEZE)) begin
            // Only live slots can die, which keeps remaining >= spawned >= 0.
            kills          = bus.alien_died & slot_active;
            kill_cnt       = 8'($countones(kills));
            slot_active_nx = slot_active & ~kills;
            remaining_nx   = remaining - kill_cnt;
            spawned_nx     = spawned - kill_cnt;

            if (remaining_nx == 8'd0) begin
                state_nx   = CLEARED;
                cleared_nx = 1'b1;
                freeze_nx  = 1'b0;
            end else if ((state == RUN) && bus.player_died) begin
                state_nx       = FREEZE;
                slot_active_nx = '0;
                spawned_nx     = 8'd0;
                freeze_nx      = 1'b1;
                tmr_load       = 1'b1;
                tmr_load_val   = 8'(FREEZE_FRAMES);
            end else if (bus.startOfFrame) begin
                if (state == FREEZE) begin
                    if (tmr_one) begin
                        state_nx  = RUN;
                        freeze_nx = 1'b0;
                        tmr_load  = 1'b1;
                    end else begin
                        tmr_tick = 1'b1;
                    end
                end else if (!tmr_zero) begin
                    tmr_tick = 1'b1;
                end else begin
                    // A slot that dies this cycle is not reusable until the next one.
                    free_slots = ~slot_active_nx & ~kills;
                    for (int i = NUM_ALIENS - 1; i >= 0; i--) begin
                        if (free_slots[i]) begin
                            pick    = '0;
                            pick[i] = 1'b1;
                        end
                    end
                    if (($countones(slot_active_nx) < MAX_ALIVE) &&
                        (spawned_nx < remaining_nx) && (pick != '0)) begin
                        spawn_req_nx   = pick;
                        slot_active_nx = slot_active_nx | pick;
                        spawned_nx     = spawned_nx + 8'd1;
                        tmr_load       = 1'b1;
                        tmr_load_val   = 8'(SPAWN_INTERVAL);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            slot_active <= '0;
            spawn_req   <= '0;
            remaining   <= 8'd0;
            spawned     <= 8'd0;
            freeze      <= 1'b0;
            cleared     <= 1'b0;
        end else begin
            state       <= state_nx;
            slot_active <= slot_active_nx;
            spawn_req   <= spawn_req_nx;
            remaining   <= remaining_nx;
            spawned     <= spawned_nx;
            freeze      <= freeze_nx;
            cleared     <= cleared_nx;
        end
    end

    assign bus.spawn_req        = spawn_req;
    assign bus.slot_active      = slot_active;
    assign bus.freeze           = freeze;
    assign bus.aliens_remaining = remaining;
    assign bus.level_cleared    = cleared;

endmodule

// File: tb/tb_alien_spawn_scheduler.sv
// Bench for alien_spawn_scheduler: directed scenarios plus random traffic,
// every cycle compared against a frame-level behavioural model.
module tb_alien_spawn_scheduler;

    localparam int NA = 4;
    localparam int MA = 3;
    localparam int TA = 10;
    localparam int SI = 4;
    localparam int FF = 6;

    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_FREEZE  = 2;
    localparam int M_CLEARED = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    alien_spawn_scheduler_if #(.NUM_ALIENS(NA)) bus ();

    alien_spawn_scheduler #(
        .NUM_ALIENS     (NA),
        .MAX_ALIVE      (MA),
        .TOTAL_ALIENS   (TA),
        .SPAWN_INTERVAL (SI),
        .FREEZE_FRAMES  (FF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vectors     = 0;
    int n_miscompares = 0;

    // Reference model state
    int          m_mode;
    logic [NA-1:0] m_active;
    logic [NA-1:0] m_spawn;
    int          m_remaining;
    int          m_spawned;
    int          m_fcnt;
    bit          m_freeze;
    bit          m_cleared;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit sof, input bit ls, input logic [NA-1:0] died,
                              input bit pd, input bit rst);
        logic [NA-1:0] killed;
        int slot;
        killed  = '0;
        m_spawn = '0;
        if (rst) begin
            m_mode = M_IDLE; m_active = '0; m_remaining = 0; m_spawned = 0;
            m_fcnt = 0; m_freeze = 0; m_cleared = 0;
        end else if (ls) begin
            m_mode = M_RUN; m_active = '0; m_remaining = TA; m_spawned = 0;
            m_fcnt = 0; m_freeze = 0; m_cleared = 0;
        end else if (m_mode == M_RUN || m_mode == M_FREEZE) begin
            for (int i = 0; i < NA; i++) begin
                if (died[i] && m_active[i]) begin
                    m_active[i] = 1'b0;
                    killed[i]   = 1'b1;
                    m_remaining--;
                    m_spawned--;
                end
            end
            if (m_remaining == 0) begin
                m_mode = M_CLEARED; m_cleared = 1; m_freeze = 0;
            end else if (m_mode == M_RUN && pd) begin
                m_mode = M_FREEZE; m_active = '0; m_spawned = 0;
                m_fcnt = FF; m_freeze = 1;
            end else if (sof && m_mode == M_FREEZE) begin
                if (m_fcnt == 1) begin
                    m_mode = M_RUN; m_fcnt = 0; m_freeze = 0;
                end else begin
                    m_fcnt--;
                end
            end else if (sof) begin
                if (m_fcnt > 0) begin
                    m_fcnt--;
                end else if ($countones(m_active) < MA && m_spawned < m_remaining) begin
                    slot = -1;
                    for (int i = NA - 1; i >= 0; i--)
                        if (!m_active[i] && !killed[i]) slot = i;
                    if (slot >= 0) begin
                        m_spawn[slot]  = 1'b1;
                        m_active[slot] = 1'b1;
                        m_spawned++;
                        m_fcnt = SI;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        check("spawn_req",        32'(bus.spawn_req),        32'(m_spawn));
        check("slot_active",      32'(bus.slot_active),      32'(m_active));
        check("freeze",           32'(bus.freeze),           32'(m_freeze));
        check("aliens_remaining", 32'(bus.aliens_remaining), 32'(m_remaining));
        check("level_cleared",    32'(bus.level_cleared),    32'(m_cleared));
    endtask

    task automatic cycle(input bit sof, input bit ls, input logic [NA-1:0] died,
                         input bit pd, input bit rst);
        @(negedge clk);
        reset            = rst;
        bus.startOfFrame = sof;
        bus.level_start  = ls;
        bus.alien_died   = died;
        bus.player_died  = pd;
        @(posedge clk);
        model_step(sof, ls, died, pd, rst);
        #1;
        compare_all();
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) begin
            cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
            cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NA-1:0] died;
        bit            sof, ls, pd, rst;
        int            guard;

        reset = 1'b1; bus.startOfFrame = 1'b0; bus.level_start = 1'b0;
        bus.alien_died = '0; bus.player_died = 1'b0;
        model_step(1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Reset state
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("rst_slot_active", 32'(bus.slot_active), 32'd0);
        check("rst_remaining",   32'(bus.aliens_remaining), 32'd0);

        // Normal spawning
        cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
        check("ls_remaining", 32'(bus.aliens_remaining), 32'(TA));
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("first_spawn", 32'(bus.spawn_req), 32'b0001);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        frames(14);
        check("three_live", 32'(bus.slot_active), 32'b0111);
        frames(10);
        check("cap_holds", 32'(bus.slot_active), 32'b0111);

        // Kill and slot reuse
        cycle(1'b0, 1'b0, 4'b0010, 1'b0, 1'b0);
        check("kill_remaining", 32'(bus.aliens_remaining), 32'd9);
        check("kill_slots",     32'(bus.slot_active), 32'b0101);
        cycle(1'b0, 1'b0, 4'b0010, 1'b0, 1'b0);
        check("dead_slot_ignored", 32'(bus.aliens_remaining), 32'd9);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("reuse_slot1", 32'(bus.spawn_req), 32'b0010);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Player death and freeze
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check("pd_slots",     32'(bus.slot_active), 32'd0);
        check("pd_freeze",    32'(bus.freeze), 32'd1);
        check("pd_remaining", 32'(bus.aliens_remaining), 32'd9);
        frames(FF - 1);
        check("still_frozen", 32'(bus.freeze), 32'd1);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("thaw", 32'(bus.freeze), 32'd0);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("spawn_after_thaw", 32'(bus.spawn_req), 32'b0001);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Kill on slot 0 in the same cycle as a spawn frame
        frames(10 + SI);
        cycle(1'b1, 1'b0, 4'b0001, 1'b0, 1'b0);
        check("kill_spawn_pick", 32'(bus.spawn_req), 32'b1000);
        check("kill_spawn_slots", 32'(bus.slot_active), 32'b1110);

        // Drain to the last alien, then final kill together with player death
        guard = 0;
        while (!(m_remaining == 1 && m_active != '0) && guard < 400) begin
            died = (m_remaining > 1) ? (m_active & (~m_active + 1'b1)) : '0;
            cycle(1'b1, 1'b0, died, 1'b0, 1'b0);
            guard++;
        end
        check("drain_last_live", 32'(bus.slot_active != '0), 32'd1);
        cycle(1'b0, 1'b0, m_active, 1'b1, 1'b0);
        check("clear_flag",      32'(bus.level_cleared), 32'd1);
        check("clear_no_freeze", 32'(bus.freeze), 32'd0);
        check("clear_remaining", 32'(bus.aliens_remaining), 32'd0);
        frames(SI + 3);
        check("clear_holds", 32'(bus.level_cleared), 32'd1);

        // Reset during freeze
        cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
        frames(2);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        frames(2);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check("rst_frz_freeze",    32'(bus.freeze), 32'd0);
        check("rst_frz_slots",     32'(bus.slot_active), 32'd0);
        check("rst_frz_remaining", 32'(bus.aliens_remaining), 32'd0);

        // Restart mid-level
        cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
        frames(SI + 3);
        cycle(1'b0, 1'b0, 4'b0001, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
        check("restart_remaining", 32'(bus.aliens_remaining), 32'(TA));
        check("restart_slots",     32'(bus.slot_active), 32'd0);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("restart_spawn", 32'(bus.spawn_req), 32'b0001);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            sof  = ($urandom_range(0, 2) == 0);
            ls   = (m_mode == M_IDLE || m_mode == M_CLEARED) ? ($urandom_range(0, 19) == 0)
                                                             : ($urandom_range(0, 299) == 0);
            died = ($urandom_range(0, 3) == 0) ? NA'($urandom) : '0;
            pd   = ($urandom_range(0, 79) == 0);
            rst  = ($urandom_range(0, 799) == 0);
            cycle(sof, ls, died, pd, rst);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
